// File: rtl/ram_arb_pkg.sv
// Shared definitions for the RAM arbiter family: default sizing, the
// circular first-one search and the debug state encoding.
package ram_arb_pkg;

    localparam int CReqCntDef   = 4;
    localparam int CBurstMaxDef = 4;
    localparam int CReqMax      = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHARE = 2'd1,
        ST_BURST = 2'd2
    } arb_state_e;

    // Returns {found, index} of the first set bit at or after ptr, wrapping at n.
    function automatic logic [3:0] rr_first(
        input logic [CReqMax-1:0] pend,
        input logic [2:0]         ptr,
        input int                 n
    );
        logic [3:0] res;
        int         idx;
        res = '0;
        for (int k = CReqMax - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= n) idx = idx - n;
            if ((k < n) && pend[idx[2:0]]) res = {1'b1, idx[2:0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/ram_arb_sx_rr_pick.sv
// Combinational round-robin picker: one-hot winner and its index, searching
// circularly from the priority pointer.
module rr_pick
    import ram_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  pend,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  win_oh,
    output logic [IW-1:0] win_idx,
    output logic          win_vld
);

    logic [CReqMax-1:0] pend_ext;
    logic [3:0]         res;

    always_comb begin
        pend_ext        = '0;
        pend_ext[N-1:0] = pend;
        res             = rr_first(pend_ext, 3'(ptr), N);
        win_vld         = res[3];
        win_idx         = IW'(res[2:0]);
        win_oh          = '0;
        if (res[3]) win_oh[win_idx] = 1'b1;
    end

endmodule

// File: rtl/ram_arb_sx.sv
// Round-robin arbiter sharing one single-port synchronous RAM between
// several requesters, with optional locked bursts and one-hot read return.
module ram_arb_sx
    import ram_arb_pkg::*;
#(
    parameter int CReqCnt   = CReqCntDef,
    parameter int CAddrLen  = 13,
    parameter int CDataLen  = 128,
    parameter int CBurstMax = CBurstMaxDef
) (
    input  logic                         AClkH,
    input  logic                         AResetH,
    input  logic                         AClkHEn,
    input  logic [CReqCnt*CAddrLen-1:0]  AReqAddr,
    input  logic [CReqCnt*CDataLen-1:0]  AReqMosi,
    input  logic [CReqCnt-1:0]           AReqWrEn,
    input  logic [CReqCnt-1:0]           AReqRdEn,
    input  logic [CReqCnt-1:0]           AReqLock,
    output logic [CReqCnt-1:0]           AGnt,
    output logic [CReqCnt-1:0]           ARdVld,
    output logic [CDataLen-1:0]          AMiso,
    output logic [CAddrLen-1:0]          ARamAddr,
    output logic [CDataLen-1:0]          ARamMosi,
    output logic                         ARamWrEn,
    output logic                         ARamRdEn,
    input  logic [CDataLen-1:0]          ARamMiso
);

    localparam int CPtrW = $clog2(CReqCnt);
    localparam int CCntW = $clog2(CBurstMax + 1);

    logic [CReqCnt-1:0] pend;
    logic [CReqCnt-1:0] win_oh;
    logic [CPtrW-1:0]   win_idx;
    logic               win_vld;
    logic               gnt_any;

    logic [CPtrW-1:0]   ptr_q, ptr_d;
    logic [CCntW-1:0]   burst_q, burst_d;
    logic [CCntW-1:0]   burst_base, burst_inc;
    logic [CReqCnt-1:0] rd_own_q, rd_own_d;
    arb_state_e         state_q, state_d;

    assign pend = AReqWrEn | AReqRdEn;

    rr_pick #(
        .N  (CReqCnt),
        .IW (CPtrW)
    ) u_pick (
        .pend    (pend),
        .ptr     (ptr_q),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .win_vld (win_vld)
    );

    always_comb begin
        gnt_any  = win_vld & AClkHEn & ~AResetH;
        AGnt     = gnt_any ? win_oh : '0;
        ARamAddr = AReqAddr[int'(win_idx)*CAddrLen +: CAddrLen];
        ARamMosi = AReqMosi[int'(win_idx)*CDataLen +: CDataLen];
        ARamWrEn = gnt_any & AReqWrEn[win_idx];
        ARamRdEn = gnt_any & AReqRdEn[win_idx];
    end

    // A burst only continues for the owner that held the previous grant; any
    // other winner, or an owner that dropped out, starts counting afresh.
    always_comb begin
        ptr_d      = ptr_q;
        burst_d    = burst_q;
        rd_own_d   = rd_own_q;
        state_d    = state_q;
        burst_base = ((state_q == ST_BURST) && (win_idx == ptr_q)) ? burst_q : '0;
        burst_inc  = burst_base + CCntW'(1);
        if (AClkHEn) begin
            rd_own_d = AGnt & AReqRdEn;
            if (gnt_any) begin
                if (AReqLock[win_idx] && (burst_inc < CCntW'(CBurstMax))) begin
                    ptr_d   = win_idx;
                    burst_d = burst_inc;
                end else begin
                    ptr_d   = (win_idx == CPtrW'(CReqCnt - 1)) ? '0 : win_idx + CPtrW'(1);
                    burst_d = '0;
                end
            end else begin
                burst_d = '0;
            end
            if (!gnt_any)            state_d = ST_IDLE;
            else if (burst_d != '0)  state_d = ST_BURST;
            else                     state_d = ST_SHARE;
        end
    end

    always_ff @(posedge AClkH) begin
        if (AResetH) begin
            ptr_q    <= '0;
            burst_q  <= '0;
            rd_own_q <= '0;
            state_q  <= ST_IDLE;
        end else begin
            ptr_q    <= ptr_d;
            burst_q  <= burst_d;
            rd_own_q <= rd_own_d;
            state_q  <= state_d;
        end
    end

    // Read return is blanked throughout reset, not just after the first edge.
    assign ARdVld = AResetH ? '0 : rd_own_q;
    assign AMiso  = ((|rd_own_q) && !AResetH) ? ARamMiso : '0;

endmodule

// File: tb/tb_ram_arb_sx.sv
// Directed bench for ram_arb_sx with a behavioural 1-cycle-latency RAM whose
// read data is zero outside the cycle after a read.
module tb_ram_arb_sx;

    localparam int N  = 4;
    localparam int AW = 13;
    localparam int DW = 128;

    logic              AClkH = 1'b0;
    logic              AResetH;
    logic              AClkHEn;
    logic [N*AW-1:0]   AReqAddr;
    logic [N*DW-1:0]   AReqMosi;
    logic [N-1:0]      AReqWrEn;
    logic [N-1:0]      AReqRdEn;
    logic [N-1:0]      AReqLock;
    logic [N-1:0]      AGnt;
    logic [N-1:0]      ARdVld;
    logic [DW-1:0]     AMiso;
    logic [AW-1:0]     ARamAddr;
    logic [DW-1:0]     ARamMosi;
    logic              ARamWrEn;
    logic              ARamRdEn;
    logic [DW-1:0]     ARamMiso;

    logic [DW-1:0]     mem [0:(1<<AW)-1];
    logic              ram_vld  = 1'b0;
    logic [DW-1:0]     ram_dout = '0;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    ram_arb_sx #(
        .CReqCnt   (N),
        .CAddrLen  (AW),
        .CDataLen  (DW),
        .CBurstMax (4)
    ) dut (
        .AClkH    (AClkH),
        .AResetH  (AResetH),
        .AClkHEn  (AClkHEn),
        .AReqAddr (AReqAddr),
        .AReqMosi (AReqMosi),
        .AReqWrEn (AReqWrEn),
        .AReqRdEn (AReqRdEn),
        .AReqLock (AReqLock),
        .AGnt     (AGnt),
        .ARdVld   (ARdVld),
        .AMiso    (AMiso),
        .ARamAddr (ARamAddr),
        .ARamMosi (ARamMosi),
        .ARamWrEn (ARamWrEn),
        .ARamRdEn (ARamRdEn),
        .ARamMiso (ARamMiso)
    );

    always #5 AClkH = ~AClkH;

    always @(posedge AClkH) begin
        if (AClkHEn) begin
            if (ARamWrEn) mem[ARamAddr] <= ARamMosi;
            ram_vld  <= ARamRdEn;
            ram_dout <= mem[ARamAddr];
        end
    end

    assign ARamMiso = ram_vld ? ram_dout : '0;

    function automatic logic [DW-1:0] pat(input int i);
        return {4{32'(32'hDA7A_0000 + i)}};
    endfunction

    task automatic tick();
        @(posedge AClkH);
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        AReqAddr[i*AW +: AW] = addr;
        AReqMosi[i*DW +: DW] = data;
    endtask

    task automatic applyStimulus(input logic [N-1:0] wr, input logic [N-1:0] rd, input logic [N-1:0] lock);
        AReqWrEn = wr;
        AReqRdEn = rd;
        AReqLock = lock;
    endtask

    task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        assert_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_ret(input string tag, input logic [N-1:0] gnt, input logic [N-1:0] vld, input logic [DW-1:0] data);
        checkOutput({tag, "_gnt"}, DW'(AGnt), DW'(gnt));
        checkOutput({tag, "_vld"}, DW'(ARdVld), DW'(vld));
        checkOutput({tag, "_miso"}, AMiso, data);
    endtask

    initial begin
        AResetH  = 1'b1;
        AClkHEn  = 1'b1;
        AReqAddr = '0;
        AReqMosi = '0;
        applyStimulus('0, '0, '0);
        for (int i = 0; i < N; i++) mem[16+i] = pat(i);

        tick();
        tick();
        #2;
        check_ret("reset", 4'b0000, 4'b0000, '0);
        checkOutput("reset_wren", DW'(ARamWrEn), '0);

        // Reads pending while reset is still high must not be granted.
        tick();
        for (int i = 0; i < N; i++) set_req(i, 13'(16 + i), '0);
        applyStimulus('0, 4'b1111, '0);
        #2;
        checkOutput("rst_pend_gnt", DW'(AGnt), '0);
        checkOutput("rst_pend_rden", DW'(ARamRdEn), '0);

        $display("[TB] round-robin reads");
        tick();
        AResetH = 1'b0;
        #2;
        check_ret("rr0", 4'b0001, 4'b0000, '0);
        checkOutput("rr0_addr", DW'(ARamAddr), DW'(13'h10));
        for (int k = 1; k <= 4; k++) begin
            tick();
            #2;
            check_ret($sformatf("rr%0d", k), 4'(1 << (k % 4)), 4'(1 << (k - 1)), pat(k - 1));
        end
        tick();
        applyStimulus('0, '0, '0);
        #2;
        check_ret("rr_tail", 4'b0000, 4'b0001, pat(0));

        $display("[TB] locked burst");
        tick();
        set_req(2, 13'h200, {4{32'h2222_2222}});
        set_req(0, 13'h201, {4{32'h0000_0000}});
        applyStimulus(4'b0101, '0, 4'b0100);
        #2;
        check_ret("burst1", 4'b0100, 4'b0000, '0);
        checkOutput("burst1_wren", DW'(ARamWrEn), DW'(1'b1));
        checkOutput("burst1_addr", DW'(ARamAddr), DW'(13'h200));
        for (int b = 2; b <= 4; b++) begin
            tick();
            #2;
            checkOutput($sformatf("burst%0d_gnt", b), DW'(AGnt), DW'(4'b0100));
        end
        tick();
        #2;
        checkOutput("burst_yield_gnt", DW'(AGnt), DW'(4'b0001));
        checkOutput("burst_yield_addr", DW'(ARamAddr), DW'(13'h201));
        tick();
        applyStimulus(4'b0100, '0, 4'b0100);
        #2;
        checkOutput("burst_again_gnt", DW'(AGnt), DW'(4'b0100));
        tick();
        applyStimulus('0, '0, '0);
        #2;
        checkOutput("burst_idle_gnt", DW'(AGnt), '0);

        $display("[TB] clock-enable gap");
        tick();
        set_req(1, 13'h11, '0);
        applyStimulus('0, 4'b0010, '0);
        #2;
        check_ret("gap_pre", 4'b0010, 4'b0000, '0);
        for (int g = 0; g < 3; g++) begin
            tick();
            AClkHEn = 1'b0;
            set_req(3, 13'h13, '0);
            applyStimulus('0, 4'b1010, '0);
            #2;
            check_ret($sformatf("gap%0d", g), 4'b0000, 4'b0010, pat(1));
        end
        tick();
        AClkHEn = 1'b1;
        #2;
        check_ret("gap_resume", 4'b1000, 4'b0010, pat(1));
        tick();
        applyStimulus('0, 4'b0010, '0);
        #2;
        check_ret("gap_next", 4'b0010, 4'b1000, pat(3));
        tick();
        applyStimulus('0, '0, '0);
        #2;
        check_ret("gap_tail", 4'b0000, 4'b0010, pat(1));

        $display("[TB] write then read-back");
        tick();
        set_req(1, 13'h100, {16{8'hA5}});
        applyStimulus(4'b0010, '0, '0);
        #2;
        check_ret("wr", 4'b0010, 4'b0000, '0);
        checkOutput("wr_mosi", ARamMosi, {16{8'hA5}});
        tick();
        set_req(3, 13'h100, '0);
        applyStimulus('0, 4'b1000, '0);
        #2;
        check_ret("rd", 4'b1000, 4'b0000, '0);
        tick();
        applyStimulus('0, '0, '0);
        #2;
        check_ret("rd_ret", 4'b0000, 4'b1000, {16{8'hA5}});
        tick();
        #2;
        check_ret("rd_after", 4'b0000, 4'b0000, '0);

        $display("[TB] reset mid-burst");
        tick();
        set_req(0, 13'h10, '0);
        applyStimulus('0, 4'b0001, 4'b0001);
        #2;
        check_ret("rb1", 4'b0001, 4'b0000, '0);
        tick();
        #2;
        check_ret("rb2", 4'b0001, 4'b0001, pat(0));
        tick();
        AResetH = 1'b1;
        set_req(2, 13'h12, '0);
        set_req(3, 13'h13, '0);
        applyStimulus('0, 4'b1101, 4'b0101);
        #2;
        check_ret("rb_rst", 4'b0000, 4'b0000, '0);
        checkOutput("rb_rst_rden", DW'(ARamRdEn), '0);
        tick();
        AResetH = 1'b0;
        applyStimulus('0, 4'b1100, 4'b0100);
        #2;
        check_ret("rb_rel", 4'b0100, 4'b0000, '0);
        for (int b = 2; b <= 4; b++) begin
            tick();
            #2;
            check_ret($sformatf("rb_burst%0d", b), 4'b0100, 4'b0100, pat(2));
        end
        tick();
        #2;
        check_ret("rb_yield", 4'b1000, 4'b0100, pat(2));
        tick();
        applyStimulus('0, 4'b0100, '0);
        #2;
        check_ret("rb_last", 4'b0100, 4'b1000, pat(3));

        $display("[TB] pointer wrap");
        tick();
        applyStimulus('0, 4'b1000, '0);
        #2;
        check_ret("wrap1", 4'b1000, 4'b0100, pat(2));
        tick();
        set_req(1, 13'h11, '0);
        applyStimulus('0, 4'b1010, '0);
        #2;
        check_ret("wrap2", 4'b0010, 4'b1000, pat(3));
        tick();
        applyStimulus('0, 4'b1000, '0);
        #2;
        check_ret("wrap3", 4'b1000, 4'b0010, pat(1));
        tick();
        #2;
        check_ret("wrap_single", 4'b1000, 4'b1000, pat(3));
        tick();
        applyStimulus('0, '0, '0);
        #2;
        check_ret("wrap_tail", 4'b0000, 4'b1000, pat(3));

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/ram_arb_sx.md
Name: ram_arb_sx

Overview:
- Round-robin arbiter that shares one single-port synchronous RAM between CReqCnt requesters.
- The RAM has 1-cycle read latency and gated read data: data appears the enabled cycle after RdEn, else zero.
- Issues at most one RAM access per enabled clock, supports optional locked bursts, and routes read data back with a one-hot valid.
- Sits between CPU/DMA/peripheral masters and the shared data RAM instance.

Parameters:
- CReqCnt, 4, number of requesters (2..8).
- CAddrLen, 13, RAM address width.
- CDataLen, 128, RAM data width.
- CBurstMax, 4, maximum consecutive grants to one locked requester (1 = no bursting).

Ports:
- AClkH  in  1  clock.
- AResetH  in  1  reset; one clock, synchronous, active-high.
- AClkHEn  in  1  clock enable; all state advances and grants occur only when 1.
- AReqAddr  in  CReqCnt*CAddrLen  per-requester address, requester i at slice i.
- AReqMosi  in  CReqCnt*CDataLen  per-requester write data.
- AReqWrEn  in  CReqCnt  write request.
- AReqRdEn  in  CReqCnt  read request.
- AReqLock  in  CReqCnt  burst lock hint, sampled with the request.
- AGnt  out  CReqCnt  one-hot; access of requester i is issued to the RAM this cycle.
- ARdVld  out  CReqCnt  one-hot; AMiso holds read data for requester i.
- AMiso  out  CDataLen  returned read data, zero when ARdVld==0.
- ARamAddr  out  CAddrLen  to RAM.
- ARamMosi  out  CDataLen  to RAM.
- ARamWrEn  out  1  to RAM.
- ARamRdEn  out  1  to RAM.
- ARamMiso  in  CDataLen  from RAM.

Behaviour:
- Request: requester i is pending when AReqWrEn[i]|AReqRdEn[i]. The request is held stable until the cycle AGnt[i]=1 and may change the next cycle.
- Grant is combinational:
  - Winner = first pending index at or after FPtr, circular order.
  - AGnt is asserted only when AClkHEn=1 and AResetH=0.
  - ARamAddr/ARamMosi/ARamWrEn/ARamRdEn are muxed from the winner. WrEn/RdEn are 0 when there is no grant; Addr/Mosi are don't-care then.
- Pointer update, on an enabled edge with a grant:
  - Winner locked (AReqLock=1) and FBurstCnt+1 < CBurstMax: FPtr=winner, FBurstCnt+=1.
  - Otherwise: FPtr=(winner+1) mod CReqCnt, FBurstCnt=0.
  - Enabled edge with no grant: FBurstCnt=0, FPtr unchanged.
  - A locked owner that drops its request loses the lock immediately.
- States:
  - IDLE: no grant.
  - SHARE: grant, burst count 0.
  - BURST: FBurstCnt>0.
  - FBurstCnt width is $clog2(CBurstMax+1). CBurstMax=1 never enters BURST.
- Read return:
  - FRdOwn (one-hot) is registered on an enabled edge as AGnt & AReqRdEn.
  - ARdVld = FRdOwn; AMiso = ARamMiso AND-masked by |FRdOwn.
  - Latency is exactly one enabled cycle. With AClkHEn=0, FRdOwn holds and ARdVld stays valid.
- Write+read from the same requester in one grant: both strobes are passed through, ARdVld asserts, data is RAM-defined (not checked).
- Back-to-back: a new grant may issue in the same cycle ARdVld is high for the previous read. Full throughput is 1 access per enabled cycle.
- Reset (synchronous, any time, including mid-burst or with a read in flight):
  - FPtr=0, FBurstCnt=0, FRdOwn=0.
  - AGnt=0, ARdVld=0, AMiso=0, ARamWrEn=0, ARamRdEn=0 while AResetH=1.
  - A read granted on the cycle reset asserts is dropped, with no ARdVld.
- FPtr wrap: index CReqCnt-1 advances to 0.

Decomposition:
- Shared package ram_arb_pkg holds:
  - Default CReqCnt, CBurstMax.
  - Function for the circular first-one search from a pointer.
  - State encoding IDLE/SHARE/BURST, used for the debug/coverage view only.
- One natural sub-module, rr_pick: combinational round-robin picker that takes the pending vector and FPtr and returns a one-hot winner plus index. It is reused by other arbiters.

Test Plan:
- Reset, then all 4 requesters pend reads at addresses 0x10..0x13 with no lock -> AGnt order 0,1,2,3,0. ARdVld one-hot one cycle after each grant; AMiso equals preloaded RAM[0x10+i].
- Requester 2 locked with continuous writes, requester 0 also pending, CBurstMax=4 -> 4 consecutive AGnt[2], then AGnt[0], then requester 2 again.
- Read granted, then AClkHEn=0 for 3 cycles -> no AGnt during the gap, ARdVld/AMiso held. On re-enable the next grant proceeds and the pointer is unchanged.
- Requester 1 writes 0xA5..A5 to 0x100, then requester 3 reads 0x100 on the next cycle -> ARdVld[3] with AMiso=0xA5..A5; AMiso=0 on every non-valid cycle.
- AResetH asserted on the cycle of a read grant during a burst -> no ARdVld follows. After release, the first grant goes to the lowest pending index ≥0 and FBurstCnt restarts.
- Single requester 3 pending only, FPtr=0 -> granted immediately; FPtr wraps to 0.
